dmem_sram_bridge: RTL
=====================

Name: dmem_sram_bridge

Overview:
- Sits directly downstream of the core's data-memory port (dmem_req/cmd/width/addr/wdata → dmem_rdata/resp/err).
- Converts each core request into a single-port synchronous SRAM access, with byte-lane steering, a grant handshake and a configurable read latency.
- Returns one response per request.
- Misaligned, illegal-width and out-of-range accesses are rejected with dmem_err and never touch the SRAM.

Parameters:
AW, 14, SRAM word-address width (capacity 2^AW 32-bit words)
BASE, 32'h0001_0000, byte address mapped to SRAM word 0
RD_LAT, 1, SRAM read latency in cycles after the grant cycle; legal range 1..4

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
dmem_req  input  1  core request valid; core holds it and all fields stable until dmem_resp
dmem_cmd  input  1  1=write, 0=read
dmem_width  input  2  0=byte, 1=half, 2=word, 3=illegal
dmem_addr  input  32  byte address
dmem_wdata  input  32  write data, right-aligned
dmem_rdata  output  32  read data, right-aligned, zero-extended
dmem_resp  output  1  one-cycle response pulse
dmem_err  output  1  error flag, valid with dmem_resp
sram_en  output  1  SRAM access request
sram_we  output  1  write enable
sram_be  output  4  byte enables
sram_addr  output  AW  word address
sram_wdata  output  32  lane-steered write data
sram_gnt  input  1  SRAM accepts the access this cycle
sram_rdata  input  32  read data, valid RD_LAT cycles after the grant cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output is 0, including sram_en, sram_we, sram_be, sram_addr, sram_wdata, dmem_rdata, dmem_resp and dmem_err. An access in flight is abandoned with no response.
- All outputs are registered.
- Legality, with off = addr[1:0] and idx = (addr − BASE) mod 2^32:
  - width==3 → illegal.
  - Half with off[0]=1 → illegal.
  - Word with off!=0 → illegal.
  - idx>>2 ≥ 2^AW → illegal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, dmem_req=1 in cycle t:
  - Latch cmd, width, off, idx[AW+1:2] and wdata.
  - Illegal request → RESP at t+1 with dmem_err=1.
  - Legal request → ISSUE at t+1.
- ISSUE: sram_en=1, sram_we=cmd, sram_addr=word index.
  - Byte write: sram_be=1<<off; sram_wdata={4{wdata[7:0]}}.
  - Half write: sram_be=3<<off; sram_wdata={2{wdata[15:0]}}.
  - Word write: sram_be=4'hF; sram_wdata=wdata.
  - Read: sram_be=4'hF.
  - Outputs are held while sram_gnt=0, with no limit on wait.
  - On sram_gnt=1 in cycle g: write → RESP at g+1; read → WAIT at g+1. sram_en drops at g+1.
- WAIT: a down-counter runs RD_LAT cycles (g+1..g+RD_LAT).
  - In cycle g+RD_LAT, capture r = sram_rdata >> (8*off), then mask to 8, 16 or 32 bits by width into dmem_rdata.
  - Next state is RESP.
- RESP: dmem_resp=1 for exactly one cycle, then IDLE.
  - dmem_err=1 only for illegal requests.
  - dmem_rdata holds its value until the next successful read capture; writes and errors leave it unchanged.
- Back-to-back: dmem_req sampled high in the cycle after RESP is a new request. The bridge never samples dmem_req in ISSUE, WAIT or RESP.
- Latency with sram_gnt tied 1, request at t:
  - read → dmem_resp at t+RD_LAT+2
  - write → dmem_resp at t+2
  - error → dmem_resp at t+1
- At most one outstanding access; sram_en is never asserted outside ISSUE.

Test Plan:
- Word read, RD_LAT=1, gnt=1, SRAM[0]=32'hDEAD_BEEF, addr=32'h0001_0000 at t → sram_en=1, sram_addr=0 at t+1; dmem_resp=1, dmem_rdata=32'hDEAD_BEEF, dmem_err=0 at t+3.
- Byte write, addr=32'h0001_0007, wdata=32'h0000_00A5 → sram_addr=1, sram_be=4'b1000, sram_wdata=32'hA5A5_A5A5, sram_we=1; resp at t+2. A following byte read of the same address returns 32'h0000_00A5.
- Half read at off=2 of word 32'h1234_5678, RD_LAT=3 → dmem_rdata=32'h0000_1234, resp at t+5.
- Illegal cases each give dmem_resp=1, dmem_err=1 at t+1, sram_en never 1, dmem_rdata unchanged:
  - half at addr 32'h0001_0001
  - word at 32'h0001_0002
  - width=3
  - addr=32'h0000_FFFC (below BASE, wraps out of range)
  - addr=BASE+4*2^AW
- sram_gnt held 0 for 5 cycles in ISSUE → sram_en and all SRAM outputs stable for 5 cycles, no resp. gnt=1 on the 6th cycle → resp RD_LAT+1 cycles later.
- rst driven low asynchronously mid-WAIT → all outputs 0 immediately, no dmem_resp after release. A new request after release completes normally.

Source files
------------

// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge: turns each core data-memory request into one single-port
// synchronous SRAM access with byte-lane steering, a grant handshake and a
// fixed read latency. Illegal requests are answered with an error and never
// reach the SRAM. Exactly one response is returned per request.
module dmem_sram_bridge #(
    parameter int unsigned AW     = 14,
    parameter logic [31:0] BASE   = 32'h0001_0000,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dmem_req,
    input  logic          dmem_cmd,
    input  logic [1:0]    dmem_width,
    input  logic [31:0]   dmem_addr,
    input  logic [31:0]   dmem_wdata,
    output logic [31:0]   dmem_rdata,
    output logic          dmem_resp,
    output logic          dmem_err,
    output logic          sram_en,
    output logic          sram_we,
    output logic [3:0]    sram_be,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic          sram_gnt,
    input  logic [31:0]   sram_rdata
);

    // Counter only has to reach RD_LAT-1, and RD_LAT never exceeds 4.
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic               cmd_q;
    logic [1:0]         width_q;
    logic [1:0]         off_q;
    logic [CNT_W-1:0]   cnt;

    logic [31:0]        idx;
    logic [1:0]         off;
    logic               misaligned;
    logic               out_of_range;
    logic               illegal;
    logic [3:0]         be_c;
    logic [31:0]        steer_c;
    logic [31:0]        shifted_c;
    logic [31:0]        rdata_c;

    // Byte offset into the SRAM window; wraps for addresses below BASE.
    assign idx          = dmem_addr - BASE;
    assign off          = dmem_addr[1:0];
    assign out_of_range = (idx >> (AW + 2)) != 32'd0;
    assign illegal      = misaligned | out_of_range;

    // Alignment rule per access width; width 3 is never legal.
    always_comb begin
        misaligned = 1'b1;
        case (dmem_width)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off != 2'd0);
            default: misaligned = 1'b1;
        endcase
    end

    // Byte enables and replicated write data for the incoming request.
    always_comb begin
        be_c    = 4'hF;
        steer_c = dmem_wdata;
        if (dmem_cmd) begin
            case (dmem_width)
                2'd0: begin
                    be_c    = 4'b0001 << off;
                    steer_c = {4{dmem_wdata[7:0]}};
                end
                2'd1: begin
                    be_c    = 4'b0011 << off;
                    steer_c = {2{dmem_wdata[15:0]}};
                end
                default: begin
                    be_c    = 4'hF;
                    steer_c = dmem_wdata;
                end
            endcase
        end
    end

    // Right-align the addressed lanes of the SRAM word and zero-extend.
    always_comb begin
        shifted_c = sram_rdata >> {off_q, 3'b000};
        case (width_q)
            2'd0:    rdata_c = {24'd0, shifted_c[7:0]};
            2'd1:    rdata_c = {16'd0, shifted_c[15:0]};
            default: rdata_c = shifted_c;
        endcase
    end

    // Request sequencing with registered core-side and SRAM-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cmd_q      <= 1'b0;
            width_q    <= 2'd0;
            off_q      <= 2'd0;
            cnt        <= '0;
            dmem_rdata <= 32'd0;
            dmem_resp  <= 1'b0;
            dmem_err   <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_be    <= 4'd0;
            sram_addr  <= '0;
            sram_wdata <= 32'd0;
        end else begin
            dmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (dmem_req) begin
                        cmd_q   <= dmem_cmd;
                        width_q <= dmem_width;
                        off_q   <= off;
                        if (illegal) begin
                            state     <= RESP;
                            dmem_resp <= 1'b1;
                            dmem_err  <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            sram_en    <= 1'b1;
                            sram_we    <= dmem_cmd;
                            sram_be    <= be_c;
                            sram_addr  <= idx[AW+1:2];
                            sram_wdata <= steer_c;
                        end
                    end
                end
                ISSUE: begin
                    // Hold the access on the SRAM port until it is granted.
                    if (sram_gnt) begin
                        sram_en    <= 1'b0;
                        sram_we    <= 1'b0;
                        sram_be    <= 4'd0;
                        sram_addr  <= '0;
                        sram_wdata <= 32'd0;
                        if (cmd_q) begin
                            state     <= RESP;
                            dmem_resp <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(RD_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        dmem_rdata <= rdata_c;
                        dmem_resp  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    dmem_err <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
